// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt requester: synchronises/latches sources, waits for an
// instruction boundary, issues a one-cycle trap pulse and drives fetch redirects.
module irq_trap_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq_in,
    input  logic        frc_cntr_val_leq,
    input  logic        csr_rmie,
    input  logic        csr_meie,
    input  logic        csr_mtie,
    input  logic        cpu_stat_pc,
    input  logic [31:2] pc_if,
    input  logic        cmd_mret_ex,
    input  logic [31:2] csr_mtvec_ex,
    input  logic [31:2] csr_mepc_ex,
    output logic        interrupts_in_pc_state,
    output logic        g_interrupt,
    output logic        timer_cause,
    output logic [1:0]  g_interrupt_priv,
    output logic [1:0]  g_current_priv,
    output logic [31:2] pc_excep,
    output logic        trap_redirect,
    output logic [31:2] trap_target,
    output logic        irq_busy
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_TAKE       = 2'd2,
        ST_IN_HANDLER = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_prev_reg;
    logic                   ext_pend_reg;
    logic                   mret_redirect_reg;
    logic                   g_interrupt_reg;
    logic                   timer_cause_reg;
    logic [31:2]            pc_excep_reg;
    logic [31:2]            trap_target_reg;

    logic ext_rise;
    logic req_ext;
    logic req_tmr;
    logic req;
    logic take_edge;

    assign ext_rise  = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
    assign req_ext   = ext_pend_reg & csr_meie;
    assign req_tmr   = frc_cntr_val_leq & csr_mtie;
    assign req       = csr_rmie & (req_ext | req_tmr);
    assign take_edge = (state_reg == ST_PENDING) & ~cmd_mret_ex & req & cpu_stat_pc;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; mret in PENDING wins over a take
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (cmd_mret_ex || !req) begin
                    state_next = ST_IDLE;
                end else if (cpu_stat_pc) begin
                    state_next = ST_TAKE;
                end
            end
            ST_TAKE: begin
                state_next = ST_IN_HANDLER;
            end
            ST_IN_HANDLER: begin
                if (cmd_mret_ex) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        interrupts_in_pc_state = 1'b0;
        trap_redirect          = mret_redirect_reg;
        irq_busy               = 1'b0;
        case (state_reg)
            ST_TAKE: begin
                interrupts_in_pc_state = 1'b1;
                trap_redirect          = 1'b1;
                irq_busy               = 1'b1;
            end
            ST_IN_HANDLER: begin
                irq_busy = 1'b1;
            end
            default: ;
        endcase
    end

    // Synchroniser, pending latch and captured trap context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg          <= '0;
            sync_prev_reg     <= 1'b0;
            ext_pend_reg      <= 1'b0;
            mret_redirect_reg <= 1'b0;
            g_interrupt_reg   <= 1'b0;
            timer_cause_reg   <= 1'b0;
            pc_excep_reg      <= '0;
            trap_target_reg   <= '0;
        end else begin
            sync_reg      <= {sync_reg[SYNC_STAGES-2:0], ext_irq_in};
            sync_prev_reg <= sync_reg[SYNC_STAGES-1];

            if (ext_rise) begin
                ext_pend_reg <= 1'b1;
            end else if (state_reg == ST_TAKE && g_interrupt_reg) begin
                ext_pend_reg <= 1'b0;
            end

            mret_redirect_reg <= cmd_mret_ex;

            // An mret redirect is the later one seen by fetch, so it wins
            if (cmd_mret_ex) begin
                trap_target_reg <= csr_mepc_ex;
            end else if (state_reg == ST_TAKE) begin
                trap_target_reg <= csr_mtvec_ex;
            end

            if (take_edge) begin
                pc_excep_reg    <= pc_if;
                g_interrupt_reg <= req_ext;
                timer_cause_reg <= ~req_ext;
            end else if (state_reg == ST_IN_HANDLER && cmd_mret_ex) begin
                g_interrupt_reg <= 1'b0;
                timer_cause_reg <= 1'b0;
            end
        end
    end

    assign g_interrupt      = g_interrupt_reg;
    assign timer_cause      = timer_cause_reg;
    assign pc_excep         = pc_excep_reg;
    assign trap_target      = trap_target_reg;
    assign g_interrupt_priv = 2'b11;
    assign g_current_priv   = 2'b11;

endmodule

// File: doc/irq_trap_ctrl.md
# irq_trap_ctrl

Machine-mode interrupt requester that sits between the external interrupt pin, the free-running-counter compare flag and the CSR array. It synchronises and latches interrupt sources, applies the CSR enable bits, waits for an instruction boundary, then issues a one-cycle trap pulse with the captured PC and cause. It also drives fetch redirects to the trap vector on entry and to the saved EPC on `mret`.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on `ext_irq_in`; legal values are 2–4.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high; all flops clear immediately on assertion.
- `ext_irq_in` input 1: external interrupt, asynchronous, level; only its rising edge is latched.
- `frc_cntr_val_leq` input 1: timer compare flag, synchronous level.
- `csr_rmie` input 1: mstatus.MIE global enable.
- `csr_meie` input 1: mie.MEIE enable.
- `csr_mtie` input 1: mie.MTIE enable.
- `cpu_stat_pc` input 1: CPU is at an instruction boundary (PC state).
- `pc_if` input [31:2]: PC of the next instruction to execute.
- `cmd_mret_ex` input 1: `mret` executing; one-cycle pulse.
- `csr_mtvec_ex` input [31:2]: trap vector, already vectored by cause.
- `csr_mepc_ex` input [31:2]: saved exception PC.
- `interrupts_in_pc_state` output 1: trap-take pulse to the CSR array; reset 0.
- `g_interrupt` output 1: taken cause is external; reset 0.
- `timer_cause` output 1: taken cause is timer; reset 0.
- `g_interrupt_priv` output [1:0]: interrupt privilege; constant 2'b11.
- `g_current_priv` output [1:0]: current privilege; constant 2'b11.
- `pc_excep` output [31:2]: captured PC; reset 0.
- `trap_redirect` output 1: fetch-redirect pulse; reset 0.
- `trap_target` output [31:2]: redirect address; reset 0.
- `irq_busy` output 1: high while in TAKE or IN_HANDLER; reset 0.

## Operation
- **External pending latch `ext_pend`.**
  - Set on a rising edge of the synchronised `ext_irq_in`.
  - Cleared in the TAKE cycle when the external cause is taken.
  - If set and clear occur in the same cycle, set wins.
- **Requests.**
  - `req_ext = ext_pend & csr_meie`
  - `req_tmr = frc_cntr_val_leq & csr_mtie`
  - `req = csr_rmie & (req_ext | req_tmr)`
  - External has priority over timer.
- **State machine states:** IDLE, PENDING, TAKE, IN_HANDLER.
- **IDLE**
  - `req` → PENDING.
- **PENDING**
  - `req` falls → IDLE. `ext_pend` is kept.
  - `cpu_stat_pc & req` → TAKE. On this edge:
    - `pc_excep <= pc_if`
    - `g_interrupt <= req_ext`
    - `timer_cause <= ~req_ext`
- **TAKE** (exactly one cycle)
  - `interrupts_in_pc_state = 1`, `trap_redirect = 1`.
  - `trap_target <= csr_mtvec_ex`, sampled in this cycle so the CSR sees a stable cause.
  - Next state → IN_HANDLER.
- **IN_HANDLER**
  - Nested interrupts are ignored.
  - `cmd_mret_ex` → IDLE, with a one-cycle `trap_redirect` and `trap_target = csr_mepc_ex`. `g_interrupt` and `timer_cause` clear on the same edge.
- **`trap_target` width rule:** updated only when `trap_redirect` is generated; otherwise it holds its value. All PCs are word addresses, [31:2]; no arithmetic is performed.
- **`cmd_mret_ex` outside IN_HANDLER:** redirect to `csr_mepc_ex` anyway, with no state change. In PENDING, `mret` takes precedence and the state returns to IDLE.

## Timing
- **Edge detect:** `ext_irq_in` rise → `ext_pend` high after `SYNC_STAGES + 1` clocks.
- **Entry to PENDING:** `req` true in IDLE → PENDING on the next edge.
- **Trap take:** `cpu_stat_pc` sampled high in PENDING → `interrupts_in_pc_state`/`trap_redirect` high the following cycle, for exactly 1 cycle. Minimum latency from `req` to the pulse is 2 cycles.
- **`trap_target` on entry:** valid in the cycle after TAKE and held.
- **`mret` exit:** `cmd_mret_ex` in IN_HANDLER → `trap_redirect` pulse on the next cycle, with `trap_target = csr_mepc_ex` as sampled at the `mret` edge. `irq_busy` falls on the same edge.
- **Re-take:** a new request seen in the cycle after returning to IDLE re-enters PENDING. There is no back-to-back take without at least one IDLE cycle.
- **Reset mid-operation:** state → IDLE, synchroniser and `ext_pend` cleared, and every output returns to its reset value asynchronously.

## Test plan
- **External interrupt entry.** Setup: `csr_rmie=1`, `csr_meie=1`, `csr_mtvec_ex=30'h40`, `pc_if=30'h123`. Pulse `ext_irq_in`, then raise `cpu_stat_pc`.
  - Required: `interrupts_in_pc_state` pulses for 1 cycle, `g_interrupt=1`, `pc_excep=30'h123`, `trap_target=30'h40`, `irq_busy=1`.
- **Timer interrupt and return.** Setup: `frc_cntr_val_leq=1`, `csr_mtie=1`, `csr_meie=0`.
  - Required on take: `timer_cause=1`, `g_interrupt=0`.
  - Then `cmd_mret_ex` with `csr_mepc_ex=30'h200` → `trap_redirect` pulse with `trap_target=30'h200`, then IDLE.
- **Simultaneous sources.** External and timer both requested.
  - Required: the external is taken first. After `mret`, the timer is taken next with `timer_cause=1`.
- **Gating.** Case 1: `csr_rmie=0` with `ext_pend` set; hold `cpu_stat_pc=1` for 10 cycles.
  - Required: no pulse; `ext_pend` is retained; raising `csr_rmie` leads to a take 2 cycles later.
  - Case 2: `csr_rmie` drops while in PENDING.
  - Required: return to IDLE with no pulse.
- **Reset mid-operation.** Assert `rst` in IN_HANDLER, asynchronously off a clock edge.
  - Required: all outputs go to 0 immediately, apart from the constant privilege outputs; after release, no trap occurs until a new `ext_irq_in` edge.
